// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the reaction-time game controller.
// Holds the state codes exposed on round_sequencer.State, the fixed
// register-file addresses for the run count and best score, the score
// saturation value, and a small min() helper for best-score tracking.
package game_pkg;

    localparam int SCORE_W = 13;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_GO    = 3'd2,
        ST_STORE = 3'd3,
        ST_FOUL  = 3'd4,
        ST_DONE  = 3'd5,
        ST_CLEAR = 3'd6
    } state_e;

    localparam logic [2:0]         ADDR_RUN  = 3'd0;
    localparam logic [2:0]         ADDR_BEST = 3'd5;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 13'h1FFF;

    function automatic logic [SCORE_W-1:0] score_min(
        input logic [SCORE_W-1:0] a,
        input logic [SCORE_W-1:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/delay_lfsr.sv
// delay_lfsr: free-running 10-bit Fibonacci LFSR (taps 10,7) that supplies
// the random part of the pre-GO wait. It steps on every Clock cycle so the
// value sampled at the Start press depends on how long the player waited.
//
// Ports:
//   Clock - system clock
//   CLRN  - asynchronous active-low reset, loads SEED
//   lfsr  - current LFSR value, never all-zero
module delay_lfsr #(
    parameter logic [9:0] SEED = 10'h2A5
) (
    input  logic       Clock,
    input  logic       CLRN,
    output logic [9:0] lfsr
);

    logic [9:0] lfsr_q;
    logic [9:0] lfsr_d;
    logic       feedback;

    always_comb begin
        feedback = lfsr_q[9] ^ lfsr_q[6];
        lfsr_d   = {lfsr_q[8:0], feedback};
        // x^10 + x^7 + 1 is primitive, so a nonzero seed never reaches
        // zero; the reload only guards against a corrupted register.
        if (lfsr_q == 10'd0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: multi-round reaction-time game controller.
// Arms the random delay, gates/clears the score counter, drives the LEDs,
// writes each round's score, the run count and the best score into the 8x13
// register file, and after the last round scans the stored scores onto the
// DATAQ display path.
//
// Ports:
//   Clock, CLRN        - clock, asynchronous active-low reset
//   Tick               - 1 kHz enable, one Clock wide
//   Start, Hit,
//   GameReset          - debounced button levels (rising edge acts)
//   DelayDone          - random-delay counter expired
//   Score              - live score counter value (ms)
//   RQ                 - regfile read address for DATAQ
//   WA, LD_DATA, WR    - regfile write port
//   DelayLoad          - one-cycle pulse loading DelayValue
//   DelayValue         - wait length in ms, 1024..2047
//   ScoreEn, ScoreClr  - score counter enable / synchronous clear
//   GreenLed, RedLed   - react-now / foul-or-game-over indicators
//   State              - current FSM state code (debug visibility)
//
// Write port: WR, WA and LD_DATA are registered and change together; each
// WR=1 cycle is exactly one write, captured by the regfile on the next
// Clock edge. WA and LD_DATA read as zero when WR is low.
//
// This block's reset leaves the regfile untouched and lands in IDLE; a
// GameReset press runs the CLEAR pass that initialises the stored scores.
module round_sequencer #(
    parameter int         SCORE_W    = 13,
    parameter int         ROUNDS     = 4,
    parameter int         SCAN_TICKS = 1000,
    parameter int         FOUL_TICKS = 1000,
    parameter logic [9:0] LFSR_SEED  = 10'h2A5
) (
    input  logic               Clock,
    input  logic               CLRN,
    input  logic               Tick,
    input  logic               Start,
    input  logic               Hit,
    input  logic               GameReset,
    input  logic               DelayDone,
    input  logic [SCORE_W-1:0] Score,
    output logic [2:0]         RQ,
    output logic [2:0]         WA,
    output logic [SCORE_W-1:0] LD_DATA,
    output logic               WR,
    output logic               DelayLoad,
    output logic [10:0]        DelayValue,
    output logic               ScoreEn,
    output logic               ScoreClr,
    output logic               GreenLed,
    output logic               RedLed,
    output logic [2:0]         State
);

    import game_pkg::*;

    localparam logic [2:0] ROUNDS_C  = 3'(ROUNDS);
    localparam logic [9:0] FOUL_LAST = 10'(FOUL_TICKS - 1);
    localparam logic [9:0] SCAN_LAST = 10'(SCAN_TICKS - 1);

    // ------------------------------------------------------------------
    // Random delay source
    // ------------------------------------------------------------------
    logic [9:0] lfsr;

    delay_lfsr #(
        .SEED (LFSR_SEED)
    ) u_delay_lfsr (
        .Clock (Clock),
        .CLRN  (CLRN),
        .lfsr  (lfsr)
    );

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [2:0]         run_q, run_d;
    logic [SCORE_W-1:0] best_q, best_d;
    logic [9:0]         tcnt_q, tcnt_d;
    logic [1:0]         step_q, step_d;
    logic [SCORE_W-1:0] score_q, score_d;

    logic start_hist_q, start_hist_d;
    logic hit_hist_q, hit_hist_d;
    logic grst_hist_q, grst_hist_d;

    logic [2:0]         rq_q, rq_d;
    logic [2:0]         wa_q, wa_d;
    logic [SCORE_W-1:0] ld_data_q, ld_data_d;
    logic               wr_q, wr_d;
    logic               delay_load_q, delay_load_d;
    logic [10:0]        delay_value_q, delay_value_d;
    logic               score_en_q, score_en_d;
    logic               score_clr_q, score_clr_d;
    logic               green_q, green_d;
    logic               red_q, red_d;

    logic start_edge;
    logic hit_edge;
    logic grst_edge;
    logic [2:0] run_inc;

    // Rising-edge detect: a held button yields a single edge.
    assign start_edge = Start & ~start_hist_q;
    assign hit_edge   = Hit & ~hit_hist_q;
    assign grst_edge  = GameReset & ~grst_hist_q;
    assign run_inc    = run_q + 3'd1;

    always_comb begin
        state_d       = state_q;
        run_d         = run_q;
        best_d        = best_q;
        tcnt_d        = tcnt_q;
        step_d        = step_q;
        score_d       = score_q;
        start_hist_d  = Start;
        hit_hist_d    = Hit;
        grst_hist_d   = GameReset;
        rq_d          = rq_q;
        wa_d          = 3'd0;
        ld_data_d     = '0;
        wr_d          = 1'b0;
        delay_load_d  = 1'b0;
        delay_value_d = delay_value_q;
        score_clr_d   = 1'b0;
        score_en_d    = 1'b0;
        green_d       = 1'b0;
        red_d         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d       = ST_ARM;
                    score_clr_d   = 1'b1;
                    delay_load_d  = 1'b1;
                    delay_value_d = {1'b1, lfsr};
                end
            end

            ST_ARM: begin
                // An early Hit beats a simultaneous DelayDone.
                if (hit_edge) begin
                    state_d = ST_FOUL;
                    tcnt_d  = 10'd0;
                end else if (DelayDone) begin
                    state_d = ST_GO;
                end
            end

            ST_GO: begin
                // A saturated counter is a miss and is stored as-is.
                if (hit_edge || (Score == SCORE_MAX)) begin
                    state_d   = ST_STORE;
                    step_d    = 2'd0;
                    score_d   = Score;
                    wr_d      = 1'b1;
                    wa_d      = run_inc;
                    ld_data_d = Score;
                end
            end

            ST_STORE: begin
                // Outputs registered here belong to the following step:
                // step_q names the write currently on the port.
                unique case (step_q)
                    2'd0: begin
                        step_d    = 2'd1;
                        wr_d      = 1'b1;
                        wa_d      = ADDR_RUN;
                        ld_data_d = {{(SCORE_W-3){1'b0}}, run_inc};
                        run_d     = run_inc;
                    end
                    2'd1: begin
                        step_d    = 2'd2;
                        wr_d      = 1'b1;
                        wa_d      = ADDR_BEST;
                        ld_data_d = score_min(best_q, score_q);
                        best_d    = score_min(best_q, score_q);
                    end
                    default: begin
                        step_d = 2'd0;
                        if (run_q == ROUNDS_C) begin
                            state_d = ST_DONE;
                            tcnt_d  = 10'd0;
                            rq_d    = 3'd1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                endcase
            end

            ST_FOUL: begin
                if (Tick) begin
                    if (tcnt_q == FOUL_LAST) begin
                        state_d = ST_IDLE;
                        tcnt_d  = 10'd0;
                    end else begin
                        tcnt_d = tcnt_q + 10'd1;
                    end
                end
            end

            ST_DONE: begin
                // Start is deliberately ignored; only GameReset leaves.
                if (Tick) begin
                    if (tcnt_q == SCAN_LAST) begin
                        tcnt_d = 10'd0;
                        rq_d   = (rq_q == ROUNDS_C) ? 3'd1 : rq_q + 3'd1;
                    end else begin
                        tcnt_d = tcnt_q + 10'd1;
                    end
                end
            end

            ST_CLEAR: begin
                // wa_q doubles as the clear address counter.
                if (wa_q == ADDR_BEST) begin
                    state_d = ST_IDLE;
                    run_d   = 3'd0;
                    best_d  = SCORE_MAX;
                end else begin
                    wr_d      = 1'b1;
                    wa_d      = wa_q + 3'd1;
                    ld_data_d = ((wa_q + 3'd1) == ADDR_BEST) ? SCORE_MAX : '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // GameReset overrides everything, including an in-flight STORE
        // or CLEAR (which restarts at address 0).
        if (grst_edge) begin
            state_d      = ST_CLEAR;
            run_d        = run_q;
            best_d       = best_q;
            step_d       = 2'd0;
            tcnt_d       = 10'd0;
            wr_d         = 1'b1;
            wa_d         = ADDR_RUN;
            ld_data_d    = '0;
            delay_load_d = 1'b0;
            score_clr_d  = 1'b0;
        end

        // Level outputs follow the state being entered.
        green_d    = (state_d == ST_GO);
        score_en_d = (state_d == ST_GO);
        red_d      = (state_d == ST_FOUL) || (state_d == ST_DONE);

        if (state_d == ST_CLEAR) begin
            rq_d = 3'd0;
        end else if (state_d != ST_DONE) begin
            rq_d = run_d;
        end
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state_q       <= ST_IDLE;
            run_q         <= 3'd0;
            best_q        <= SCORE_MAX;
            tcnt_q        <= 10'd0;
            step_q        <= 2'd0;
            score_q       <= '0;
            start_hist_q  <= 1'b0;
            hit_hist_q    <= 1'b0;
            grst_hist_q   <= 1'b0;
            rq_q          <= 3'd0;
            wa_q          <= 3'd0;
            ld_data_q     <= '0;
            wr_q          <= 1'b0;
            delay_load_q  <= 1'b0;
            delay_value_q <= 11'd0;
            score_en_q    <= 1'b0;
            score_clr_q   <= 1'b0;
            green_q       <= 1'b0;
            red_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            best_q        <= best_d;
            tcnt_q        <= tcnt_d;
            step_q        <= step_d;
            score_q       <= score_d;
            start_hist_q  <= start_hist_d;
            hit_hist_q    <= hit_hist_d;
            grst_hist_q   <= grst_hist_d;
            rq_q          <= rq_d;
            wa_q          <= wa_d;
            ld_data_q     <= ld_data_d;
            wr_q          <= wr_d;
            delay_load_q  <= delay_load_d;
            delay_value_q <= delay_value_d;
            score_en_q    <= score_en_d;
            score_clr_q   <= score_clr_d;
            green_q       <= green_d;
            red_q         <= red_d;
        end
    end

    assign RQ         = rq_q;
    assign WA         = wa_q;
    assign LD_DATA    = ld_data_q;
    assign WR         = wr_q;
    assign DelayLoad  = delay_load_q;
    assign DelayValue = delay_value_q;
    assign ScoreEn    = score_en_q;
    assign ScoreClr   = score_clr_q;
    assign GreenLed   = green_q;
    assign RedLed     = red_q;
    assign State      = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// tb_round_sequencer: directed bench for round_sequencer. Inputs are driven
// on the falling clock edge and outputs sampled there too. Register-file
// writes are logged with their cycle number and compared to expected lists.
module tb_round_sequencer;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        start;
    logic        hit;
    logic        grst;
    logic        delay_done;
    logic [12:0] score;
    logic [2:0]  rq;
    logic [2:0]  wa;
    logic [12:0] ld_data;
    logic        wr;
    logic        delay_load;
    logic [10:0] delay_value;
    logic        score_en;
    logic        score_clr;
    logic        green_led;
    logic        red_led;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tick_cnt = 0;
    logic tick_en = 1'b0;

    logic [15:0] got_q[$];
    int          got_cyc[$];
    logic [15:0] exp_q[$];
    logic [12:0] rf[0:7];
    logic [9:0]  m_lfsr;

    round_sequencer dut (
        .Clock      (clk),
        .CLRN       (rst_n),
        .Tick       (tick),
        .Start      (start),
        .Hit        (hit),
        .GameReset  (grst),
        .DelayDone  (delay_done),
        .Score      (score),
        .RQ         (rq),
        .WA         (wa),
        .LD_DATA    (ld_data),
        .WR         (wr),
        .DelayLoad  (delay_load),
        .DelayValue (delay_value),
        .ScoreEn    (score_en),
        .ScoreClr   (score_clr),
        .GreenLed   (green_led),
        .RedLed     (red_led),
        .State      (state)
    );

    // ---------------- clock / reset / tick ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            tick = tick_en && !tick;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tick) tick_cnt <= tick_cnt + 1;
        if (wr) rf[wa] <= ld_data;
    end

    // Reference 10-bit LFSR, taps 10 and 7, shifted left each cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 10'h2A5;
        else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    end

    always @(negedge clk) begin
        if (wr === 1'b1) begin
            got_q.push_back({wa, ld_data});
            got_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic play_round(input logic [12:0] s);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(1);
        delay_done = 1'b1;
        step(1);
        delay_done = 1'b0;
        score = s;
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        step(4);
        score = 13'd0;
    endtask

    task automatic press_grst();
        grst = 1'b1;
        step(1);
        grst = 1'b0;
        step(7);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state);
        end
        checks++;
        if (rq !== 3'd0) begin
            errors++;
            $display("FAIL reset_rq: got %0d expected 0", rq);
        end
        checks++;
        if ({wr, wa, ld_data, delay_load, delay_value, score_en, score_clr, green_led, red_led} !== 33'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {wr, wa, ld_data, delay_load, delay_value, score_en, score_clr, green_led, red_led});
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_clear();
        clear_logs();
        grst = 1'b1;
        step(1);
        checks++;
        if ({state, wr, wa} !== {3'd6, 1'b1, 3'd0}) begin
            errors++;
            $display("FAIL clear_entry: got state=%0d wr=%0d wa=%0d expected 6 1 0", state, wr, wa);
        end
        step(7);
        checks++;
        if ({state, green_led, red_led, rq} !== {3'd0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL clear_exit: got state=%0d g=%0d r=%0d rq=%0d expected 0 0 0 0",
                     state, green_led, red_led, rq);
        end
        grst = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) exp_q.push_back({3'(i), 13'd0});
        exp_q.push_back({3'd5, 13'h1FFF});
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL clear_count: got %0d expected %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] !== got_cyc[0] + i) begin
                    errors++;
                    $display("FAIL clear_write%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_single_round();
        logic [10:0] exp_dv;
        clear_logs();
        exp_dv = {1'b1, m_lfsr};
        start = 1'b1;
        step(1);
        checks++;
        if ({state, delay_load, score_clr} !== {3'd1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL arm_entry: got state=%0d load=%0d clr=%0d expected 1 1 1", state, delay_load, score_clr);
        end
        checks++;
        if (delay_value !== exp_dv) begin
            errors++;
            $display("FAIL delay_value: got %h expected %h", delay_value, exp_dv);
        end
        start = 1'b0;
        step(1);
        checks++;
        if (delay_load !== 1'b0) begin
            errors++;
            $display("FAIL delay_load_pulse: got %0d expected 0", delay_load);
        end
        delay_done = 1'b1;
        step(1);
        delay_done = 1'b0;
        checks++;
        if ({state, green_led, score_en} !== {3'd2, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL go_entry: got state=%0d g=%0d en=%0d expected 2 1 1", state, green_led, score_en);
        end
        score = 13'd250;
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        checks++;
        if ({state, green_led, score_en} !== {3'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL store_entry: got state=%0d g=%0d en=%0d expected 3 0 0", state, green_led, score_en);
        end
        step(3);
        checks++;
        if ({state, wr, rq} !== {3'd0, 1'b0, 3'd1}) begin
            errors++;
            $display("FAIL store_exit: got state=%0d wr=%0d rq=%0d expected 0 0 1", state, wr, rq);
        end
        score = 13'd0;
        step(1);
        exp_q.push_back({3'd1, 13'd250});
        exp_q.push_back({3'd0, 13'd1});
        exp_q.push_back({3'd5, 13'd250});
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL round_count: got %0d expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i] || got_cyc[i] !== got_cyc[0] + i) begin
                    errors++;
                    $display("FAIL round_write%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_four_rounds();
        logic [12:0] sc[4];
        logic [12:0] best;
        logic [2:0]  prev;
        logic [2:0]  exp_rq;
        int t0;
        int waited;
        sc[0] = 13'd300; sc[1] = 13'd180; sc[2] = 13'd410; sc[3] = 13'd220;
        press_grst();
        step(1);
        clear_logs();
        best = 13'h1FFF;
        for (int i = 0; i < 4; i++) begin
            if (sc[i] < best) best = sc[i];
            exp_q.push_back({3'(i + 1), sc[i]});
            exp_q.push_back({3'd0, 13'(i + 1)});
            exp_q.push_back({3'd5, best});
            play_round(sc[i]);
        end
        step(1);
        checks++;
        if ({state, red_led, rq} !== {3'd5, 1'b1, 3'd1}) begin
            errors++;
            $display("FAIL done_entry: got state=%0d r=%0d rq=%0d expected 5 1 1", state, red_led, rq);
        end
        checks++;
        if ({rf[0], rf[5]} !== {13'd4, 13'd180}) begin
            errors++;
            $display("FAIL done_regs: got reg0=%0d reg5=%0d expected 4 180", rf[0], rf[5]);
        end
        checks++;
        if (got_q.size() !== 12) begin
            errors++;
            $display("FAIL four_count: got %0d expected 12", got_q.size());
        end else begin
            for (int i = 0; i < 12; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL four_write%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        start = 1'b1;
        step(2);
        start = 1'b0;
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL done_start_ignored: got %0d expected 5", state);
        end
        prev = 3'd1;
        tick_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_rq = (k == 3) ? 3'd1 : 3'(k + 2);
            t0 = tick_cnt;
            waited = 0;
            while (rq === prev && waited < 2600) begin
                step(1);
                waited++;
            end
            checks++;
            if (rq !== exp_rq || (tick_cnt - t0) !== 1000) begin
                errors++;
                $display("FAIL scan%0d: got rq=%0d ticks=%0d expected rq=%0d ticks=1000",
                         k, rq, tick_cnt - t0, exp_rq);
            end
            prev = rq;
        end
        tick_en = 1'b0;
        step(2);
    endtask

    task automatic test_foul();
        int t0;
        int waited;
        int red_low;
        press_grst();
        step(1);
        clear_logs();
        start = 1'b1;
        step(1);
        start = 1'b0;
        hit = 1'b1;
        delay_done = 1'b1;
        step(1);
        hit = 1'b0;
        delay_done = 1'b0;
        checks++;
        if ({state, red_led} !== {3'd4, 1'b1}) begin
            errors++;
            $display("FAIL foul_entry: got state=%0d r=%0d expected 4 1", state, red_led);
        end
        tick_en = 1'b1;
        t0 = tick_cnt;
        waited = 0;
        red_low = 0;
        while (state === 3'd4 && waited < 2600) begin
            if (red_led !== 1'b1) red_low++;
            step(1);
            waited++;
        end
        checks++;
        if (state !== 3'd0 || (tick_cnt - t0) !== 1000 || red_low !== 0) begin
            errors++;
            $display("FAIL foul_length: got state=%0d ticks=%0d red_low=%0d expected 0 1000 0",
                     state, tick_cnt - t0, red_low);
        end
        tick_en = 1'b0;
        step(2);
        checks++;
        if ({red_led, rq} !== {1'b0, 3'd0} || got_q.size() !== 0 || rf[0] !== 13'd0) begin
            errors++;
            $display("FAIL foul_nostore: got r=%0d rq=%0d writes=%0d reg0=%0d expected 0 0 0 0",
                     red_led, rq, got_q.size(), rf[0]);
        end
    endtask

    task automatic test_saturation();
        play_round(13'd250);
        clear_logs();
        start = 1'b1;
        step(1);
        start = 1'b0;
        delay_done = 1'b1;
        step(1);
        delay_done = 1'b0;
        score = 13'h1FFF;
        step(1);
        checks++;
        if ({state, wa, ld_data} !== {3'd3, 3'd2, 13'h1FFF}) begin
            errors++;
            $display("FAIL sat_store: got state=%0d wa=%0d data=%h expected 3 2 1fff", state, wa, ld_data);
        end
        step(4);
        score = 13'd0;
        exp_q.push_back({3'd2, 13'h1FFF});
        exp_q.push_back({3'd0, 13'd2});
        exp_q.push_back({3'd5, 13'd250});
        checks++;
        if (got_q.size() !== 3) begin
            errors++;
            $display("FAIL sat_count: got %0d expected 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL sat_write%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_abort();
        clear_logs();
        start = 1'b1;
        step(1);
        start = 1'b0;
        delay_done = 1'b1;
        step(1);
        delay_done = 1'b0;
        score = 13'd77;
        hit = 1'b1;
        step(1);
        hit = 1'b0;
        step(1);
        grst = 1'b1;
        step(1);
        checks++;
        if ({state, wr, wa, ld_data} !== {3'd6, 1'b1, 3'd0, 13'd0}) begin
            errors++;
            $display("FAIL abort_entry: got state=%0d wr=%0d wa=%0d data=%h expected 6 1 0 0",
                     state, wr, wa, ld_data);
        end
        grst = 1'b0;
        step(8);
        score = 13'd0;
        exp_q.push_back({3'd3, 13'd77});
        exp_q.push_back({3'd0, 13'd3});
        for (int i = 0; i < 5; i++) exp_q.push_back({3'(i), 13'd0});
        exp_q.push_back({3'd5, 13'h1FFF});
        checks++;
        if (got_q.size() !== 8) begin
            errors++;
            $display("FAIL abort_count: got %0d expected 8", got_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL abort_write%0d: got %h expected %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({state, rq} !== {3'd0, 3'd0}) begin
            errors++;
            $display("FAIL abort_exit: got state=%0d rq=%0d expected 0 0", state, rq);
        end
    endtask

    task automatic test_hit_vs_reset();
        start = 1'b1;
        step(1);
        start = 1'b0;
        delay_done = 1'b1;
        step(1);
        delay_done = 1'b0;
        hit = 1'b1;
        grst = 1'b1;
        step(1);
        checks++;
        if ({state, wa, green_led} !== {3'd6, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL hit_vs_reset: got state=%0d wa=%0d g=%0d expected 6 0 0", state, wa, green_led);
        end
        hit = 1'b0;
        grst = 1'b0;
        step(7);
        checks++;
        if (state !== 3'd0) begin
            errors++;
            $display("FAIL hit_vs_reset_exit: got %0d expected 0", state);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        hit = 1'b0;
        grst = 1'b0;
        delay_done = 1'b0;
        score = 13'd0;
        test_reset();
        test_clear();
        test_single_round();
        test_four_rounds();
        test_foul();
        test_saturation();
        test_abort();
        test_hit_vs_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
